// File: rtl/hbc_io_phy_if.sv
// Controller-side handshake bundle for the HyperBus pad PHY.
// The master modport belongs to the controller FSM, and the slave modport belongs to the PHY.
interface hbc_io_phy_if #(
    parameter int DQ_W = 8
);
    logic            tx_en;
    logic            rx_en;
    logic            rwds_drv;
    logic            tx_valid;
    logic            tx_ready;
    logic [DQ_W-1:0] tx_data;
    logic            tx_mask;
    logic            rx_valid;
    logic            rx_ready;
    logic [DQ_W-1:0] rx_data;
    logic            rx_flush;
    logic            ovf;
    logic            ovf_clr;
    logic            busy;

    modport master (
        output tx_en, rx_en, rwds_drv, tx_valid, tx_data, tx_mask,
        output rx_ready, rx_flush, ovf_clr,
        input  tx_ready, rx_valid, rx_data, ovf, busy
    );

    modport slave (
        input  tx_en, rx_en, rwds_drv, tx_valid, tx_data, tx_mask,
        input  rx_ready, rx_flush, ovf_clr,
        output tx_ready, rx_valid, rx_data, ovf, busy
    );
endinterface

// File: rtl/hbc_io_phy.sv
// Registered HyperBus DQ/RWDS pad block with a direction turnaround FSM.
// Received data is captured on oversampled RWDS edges into a small FIFO.
module hbc_io_phy #(
    parameter int DQ_W       = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int TURN_CYC   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    hbc_io_phy_if.slave     bus,
    inout  wire [DQ_W-1:0]  DQ,
    inout  wire             RWDS
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;
    localparam logic [1:0] ST_RECV  = 2'd3;

    logic [1:0]      state_reg, state_next;
    logic [TW-1:0]   turn_cnt_reg;
    logic [DQ_W-1:0] dq_reg;
    logic            rwds_reg;

    logic            sync_s1_reg, sync_s2_reg, sync_s3_reg;
    logic [DQ_W-1:0] dq_d1_reg, dq_d2_reg, dq_d3_reg;

    logic [DQ_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic            push_req, push_ok, pop_ok, ovf_set;
    logic            ovf_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (bus.tx_en) state_next = ST_DRIVE;
                      else if (bus.rx_en) state_next = ST_RECV;
            ST_DRIVE: if (!bus.tx_en) state_next = ST_TURN;
            ST_RECV:  if (!bus.rx_en || bus.tx_en) state_next = ST_TURN;
            ST_TURN:  if (turn_cnt_reg == '0) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            turn_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            // Load on TURN entry so the bus stays released for exactly TURN_CYC cycles.
            if (state_reg != ST_TURN && state_next == ST_TURN)
                turn_cnt_reg <= TW'(TURN_CYC - 1);
            else if (state_reg == ST_TURN && turn_cnt_reg != '0)
                turn_cnt_reg <= turn_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_reg   <= '0;
            rwds_reg <= 1'b0;
        end else if (state_reg == ST_DRIVE && bus.tx_valid) begin
            dq_reg   <= bus.tx_data;
            rwds_reg <= bus.tx_mask;
        end
    end

    // The pad enables decode from the registered state, so an async reset releases the pads immediately.
    assign DQ   = (state_reg == ST_DRIVE) ? dq_reg : {DQ_W{1'bz}};
    assign RWDS = (state_reg == ST_DRIVE && bus.rwds_drv) ? rwds_reg : 1'bz;

    assign bus.tx_ready = (state_reg == ST_DRIVE);
    assign bus.busy     = (state_reg != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_s1_reg <= 1'b0;
            sync_s2_reg <= 1'b0;
            sync_s3_reg <= 1'b0;
            dq_d1_reg   <= '0;
            dq_d2_reg   <= '0;
            dq_d3_reg   <= '0;
        end else begin
            sync_s1_reg <= RWDS;
            sync_s2_reg <= sync_s1_reg;
            sync_s3_reg <= sync_s2_reg;
            dq_d1_reg   <= DQ;
            dq_d2_reg   <= dq_d1_reg;
            dq_d3_reg   <= dq_d2_reg;
        end
    end

    // dq_d3 was sampled one clock before the first RWDS sample at the new level,
    // so it holds data that the sender set up ahead of the strobe.
    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_full  = (fifo_count == PW'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign push_req   = (state_reg == ST_RECV) && (sync_s2_reg != sync_s3_reg);
    assign pop_ok     = bus.rx_ready && !fifo_empty;
    assign push_ok    = push_req && (!fifo_full || pop_ok);
    assign ovf_set    = push_req && fifo_full && !pop_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (bus.rx_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg[AW-1:0]] <= dq_d3_reg;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_reg <= 1'b0;
        else if (ovf_set)
            ovf_reg <= 1'b1;
        else if (bus.ovf_clr)
            ovf_reg <= 1'b0;
    end

    assign bus.rx_valid = !fifo_empty;
    assign bus.rx_data  = mem_reg[rd_ptr_reg[AW-1:0]];
    assign bus.ovf      = ovf_reg;
endmodule
